// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending scoreboard: two combinational read ports,
// one clocked writeback port, an issue port, and optional same-cycle write forwarding.
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1,
  localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Read_register1,
  input  logic [ADDR_WIDTH-1:0] Read_register2,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  output logic                  Read_ready1,
  output logic                  Read_ready2,
  input  logic                  Write_enable,
  input  logic [ADDR_WIDTH-1:0] Write_register,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  Issue_enable,
  input  logic [ADDR_WIDTH-1:0] Issue_register,
  output logic [NUM_REGS-1:0]   Pending
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  wr_en, iss_en;
  logic                  fwd1, fwd2;

  // Index 0 is inert when hardwired: it is never written, never marked pending.
  assign wr_en  = Write_enable && !(ZERO_REG && (Write_register == '0));
  assign iss_en = Issue_enable && !(ZERO_REG && (Issue_register == '0));

  // Issue is applied after writeback so a same-index issue leaves the register pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[Write_register] = 1'b0;
    end
    if (iss_en) begin
      pending_d[Issue_register] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[Write_register] <= Write_data;
      end
      pending_q <= pending_d;
    end
  end

  // Forwarding is suppressed while reset is held so reads report the cleared state.
  assign fwd1 = BYPASS && reset && wr_en && (Write_register == Read_register1);
  assign fwd2 = BYPASS && reset && wr_en && (Write_register == Read_register2);

  assign Read_data1  = fwd1 ? Write_data : regs_q[Read_register1];
  assign Read_data2  = fwd2 ? Write_data : regs_q[Read_register2];
  assign Read_ready1 = fwd1 | ~pending_q[Read_register1];
  assign Read_ready2 = fwd2 | ~pending_q[Read_register2];

  assign Pending = pending_q;

endmodule
